// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: opcode encoding,
// FSM state encoding and a small opcode-class helper.
package univ_shift_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_SAR   = 3'd3;
  localparam logic [2:0] OP_ROL   = 3'd4;
  localparam logic [2:0] OP_ROR   = 3'd5;
  localparam logic [2:0] OP_LOAD  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // True for the shift/rotate opcodes, the only ones a burst can repeat.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SHL) && (op <= OP_ROR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Bus bundle for univ_shift_reg.
//   master: drives op, amt, in_bit, load_data, start, burst_len;
//           observes out_bits, ser_out, busy, done.
//   slave : the shift register side (opposite directions).
interface univ_shift_reg_if #(
  parameter int N = 8
);
  localparam int AW = $clog2(N);

  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic          in_bit;
  logic [N-1:0]  load_data;
  logic          start;
  logic [AW:0]   burst_len;
  logic [N-1:0]  out_bits;
  logic          ser_out;
  logic          busy;
  logic          done;

  modport master (
    output op, amt, in_bit, load_data, start, burst_len,
    input  out_bits, ser_out, busy, done
  );

  modport slave (
    input  op, amt, in_bit, load_data, start, burst_len,
    output out_bits, ser_out, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_core.sv
// Combinational shift/rotate datapath.
//   i_op   : opcode (only SHL/SHR/SAR/ROL/ROR alter the data)
//   i_amt  : shift amount
//   i_fill : fill bit for SHL/SHR
//   i_data : current register value
//   o_data : shifted value (i_data for non-shift ops)
//   o_bit  : last bit shifted out
//   o_vld  : o_bit is meaningful (shift op with non-zero amount)
module univ_shift_core
  import univ_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]            i_op,
  input  logic [$clog2(N)-1:0]  i_amt,
  input  logic                  i_fill,
  input  logic [N-1:0]          i_data,
  output logic [N-1:0]          o_data,
  output logic                  o_bit,
  output logic                  o_vld
);
  localparam int AW = $clog2(N);
  localparam logic [AW:0]  N_W   = (AW+1)'(N);
  localparam logic [N-1:0] ONES  = {N{1'b1}};
  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [AW:0]   w_lidx;   // N - amt: left-out bit index and rotate complement
  logic [AW-1:0] w_ridx;   // amt - 1: right-out bit index
  logic [N-1:0]  w_lo_mask;
  logic [N-1:0]  w_hi_mask;

  assign w_lidx    = N_W - {1'b0, i_amt};
  assign w_ridx    = i_amt - AW'(1);
  // Vacated positions: the low amt bits after a left shift, high amt bits after a right shift.
  assign w_lo_mask = ~(ONES << i_amt);
  assign w_hi_mask = ~(ONES >> i_amt);

  // Select the shifted result and the bit that left the register.
  always_comb begin
    o_data = i_data;
    o_bit  = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_data = (i_data << i_amt) | (w_lo_mask & {N{i_fill}});
        o_bit  = |(i_data & (ONE_N << w_lidx));
      end
      OP_SHR: begin
        o_data = (i_data >> i_amt) | (w_hi_mask & {N{i_fill}});
        o_bit  = |(i_data & (ONE_N << w_ridx));
      end
      OP_SAR: begin
        o_data = (i_data >> i_amt) | (w_hi_mask & {N{i_data[N-1]}});
        o_bit  = |(i_data & (ONE_N << w_ridx));
      end
      OP_ROL: begin
        // amt=0 gives a shift by N, which contributes nothing.
        o_data = (i_data << i_amt) | (i_data >> w_lidx);
        o_bit  = |(i_data & (ONE_N << w_lidx));
      end
      OP_ROR: begin
        o_data = (i_data >> i_amt) | (i_data << w_lidx);
        o_bit  = |(i_data & (ONE_N << w_ridx));
      end
      default: begin
        o_data = i_data;
        o_bit  = 1'b0;
      end
    endcase
  end

  assign o_vld = is_shift_op(i_op) && (i_amt != {AW{1'b0}});

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with burst engine.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : univ_shift_reg_if slave (opcode/amount/fill/load/burst inputs,
//           out_bits/ser_out/busy/done registered outputs)
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  univ_shift_reg_if.slave bus
);
  localparam int AW = $clog2(N);
  localparam logic [AW:0] LEN_ONE = (AW+1)'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_rem;
  logic [2:0]    r_op;
  logic [AW-1:0] r_amt;
  logic          r_fill;
  logic [N-1:0]  r_out;
  logic          r_ser;
  logic          r_busy;
  logic          r_done;

  logic          w_accept;
  logic [2:0]    w_sel_op;
  logic [AW-1:0] w_sel_amt;
  logic          w_sel_fill;
  logic [N-1:0]  w_core_data;
  logic          w_core_bit;
  logic          w_core_vld;
  logic [N-1:0]  w_out_nxt;
  logic          w_ser_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic [AW:0]   w_rem_nxt;

  // Start only counts for shift/rotate ops while idle.
  assign w_accept = (r_state == ST_IDLE) && bus.start && is_shift_op(bus.op);

  // During a burst the latched op/amt/fill drive the core; live inputs are ignored.
  assign w_sel_op   = (r_state == ST_BURST) ? r_op   : bus.op;
  assign w_sel_amt  = (r_state == ST_BURST) ? r_amt  : bus.amt;
  assign w_sel_fill = (r_state == ST_BURST) ? r_fill : bus.in_bit;

  univ_shift_core #(.N(N)) u_core (
    .i_op   (w_sel_op),
    .i_amt  (w_sel_amt),
    .i_fill (w_sel_fill),
    .i_data (r_out),
    .o_data (w_core_data),
    .o_bit  (w_core_bit),
    .o_vld  (w_core_vld)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (bus.burst_len > LEN_ONE)) begin
          w_state_nxt = ST_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (r_rem == LEN_ONE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_BURST;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next data, serial bit, status and remaining-count values.
  always_comb begin
    w_out_nxt  = r_out;
    w_ser_nxt  = r_ser;
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_rem_nxt  = r_rem;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.burst_len == {(AW+1){1'b0}}) begin
            // Zero-length burst: status pulse only, data untouched.
            w_done_nxt = 1'b1;
          end else begin
            w_out_nxt = w_core_data;
            if (w_core_vld) begin
              w_ser_nxt = w_core_bit;
            end else begin
              w_ser_nxt = r_ser;
            end
            if (bus.burst_len == LEN_ONE) begin
              w_done_nxt = 1'b1;
            end else begin
              w_rem_nxt  = bus.burst_len - LEN_ONE;
              w_busy_nxt = 1'b1;
            end
          end
        end else begin
          case (bus.op)
            OP_HOLD:  w_out_nxt = r_out;
            OP_LOAD:  w_out_nxt = bus.load_data;
            OP_CLEAR: w_out_nxt = {N{1'b0}};
            default: begin
              w_out_nxt = w_core_data;
              if (w_core_vld) begin
                w_ser_nxt = w_core_bit;
              end else begin
                w_ser_nxt = r_ser;
              end
            end
          endcase
        end
      end
      ST_BURST: begin
        w_out_nxt = w_core_data;
        if (w_core_vld) begin
          w_ser_nxt = w_core_bit;
        end else begin
          w_ser_nxt = r_ser;
        end
        w_rem_nxt = r_rem - LEN_ONE;
        if (r_rem == LEN_ONE) begin
          w_done_nxt = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_out_nxt = r_out;
      end
    endcase
  end

  // Datapath, status and burst-parameter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= {N{1'b0}};
      r_ser  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_rem  <= {(AW+1){1'b0}};
      r_op   <= OP_HOLD;
      r_amt  <= {AW{1'b0}};
      r_fill <= 1'b0;
    end else begin
      r_out  <= w_out_nxt;
      r_ser  <= w_ser_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      r_rem  <= w_rem_nxt;
      if (w_accept) begin
        r_op   <= bus.op;
        r_amt  <= bus.amt;
        r_fill <= bus.in_bit;
      end else begin
        r_op   <= r_op;
        r_amt  <= r_amt;
        r_fill <= r_fill;
      end
    end
  end

  assign bus.out_bits = r_out;
  assign bus.ser_out  = r_ser;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule
